// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Receive-side checker for the one-hot traffic light bus. Decodes the light
//   code to a phase and checks one-hot legality, phase order and per-phase
//   dwell time. It also counts completed light cycles (yellow->red).
//   Errors are sticky until clr_err is pulsed in FAULT.
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   light     4-bit code: 1000 black, 0100 red, 0010 green, 0001 yellow
//   clr_err   clears the sticky error (FAULT only) and returns to SYNC
//   phase     decoded phase of the last accepted code
//   phase_vld high while in RUN
//   err       sticky error flag
//   err_code  first error cause (1 one-hot, 2 order, 3 short, 4 long)
//   cycles    saturating count of yellow->red transitions
//   dwell     saturating count of clocks the current code has been held
module traffic_light_monitor #(
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 15,
  parameter int unsigned DW_W      = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       light,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_vld,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] cycles,
  output logic [DW_W-1:0]  dwell
);

  typedef enum logic [1:0] {
    SYNC  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    E_NONE    = 3'd0,
    E_ONEHOT  = 3'd1,
    E_ILLEGAL = 3'd2,
    E_SHORT   = 3'd3,
    E_LONG    = 3'd4
  } err_e;

  localparam logic [3:0] L_BLACK  = 4'b1000;
  localparam logic [3:0] L_RED    = 4'b0100;
  localparam logic [3:0] L_GREEN  = 4'b0010;
  localparam logic [3:0] L_YELLOW = 4'b0001;

  localparam logic [DW_W-1:0] MIN_DW = DW_W'(MIN_DWELL);
  localparam logic [DW_W-1:0] MAX_DW = DW_W'(MAX_DWELL);
  localparam logic [DW_W-1:0] DW_ONE = DW_W'(1);

  state_e             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic               phase_vld_q, phase_vld_d;
  logic               err_q, err_d;
  err_e               err_code_q, err_code_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [3:0]         last_code_q, last_code_d;

  err_e               cause;
  logic               legal_step;
  logic [DW_W-1:0]    dwell_inc;
  logic [CNT_W-1:0]   cycles_inc;

  function automatic logic [1:0] decode(input logic [3:0] code);
    case (code)
      L_RED:    decode = 2'b01;
      L_GREEN:  decode = 2'b10;
      L_YELLOW: decode = 2'b11;
      default:  decode = 2'b00;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    cycles_d    = cycles_q;
    dwell_d     = dwell_q;
    last_code_d = last_code_q;
    cause       = E_NONE;

    dwell_inc  = (dwell_q == '1) ? dwell_q : dwell_q + DW_ONE;
    cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
    legal_step = ((last_code_q == L_BLACK)  && (light == L_RED))   ||
                 ((last_code_q == L_RED)    && (light == L_GREEN)) ||
                 ((last_code_q == L_GREEN)  && (light == L_YELLOW))||
                 ((last_code_q == L_YELLOW) && (light == L_RED));

    case (state_q)
      SYNC: begin
        if ((light == L_BLACK) || (light == L_RED)) begin
          last_code_d = light;
          phase_d     = decode(light);
          dwell_d     = DW_ONE;
          state_d     = RUN;
        end
      end
      RUN: begin
        // Same-code and code-change cases are disjoint, so the if/else chain
        // below realises the one-hot > order > short > long priority.
        if (light == last_code_q) begin
          if ((last_code_q != L_BLACK) && (dwell_q == MAX_DW)) cause = E_LONG;
          else dwell_d = dwell_inc;
        end else if (!$onehot(light)) begin
          cause = E_ONEHOT;
        end else if (!legal_step) begin
          cause = E_ILLEGAL;
        end else if ((last_code_q != L_BLACK) && (dwell_q < MIN_DW)) begin
          cause = E_SHORT;
        end else begin
          if (last_code_q == L_YELLOW) cycles_d = cycles_inc;
          last_code_d = light;
          phase_d     = decode(light);
          dwell_d     = DW_ONE;
        end
        if (cause != E_NONE) begin
          state_d    = FAULT;
          err_d      = 1'b1;
          err_code_d = cause;
        end
      end
      FAULT: begin
        if (clr_err) begin
          err_d      = 1'b0;
          err_code_d = E_NONE;
          dwell_d    = '0;
          state_d    = SYNC;
        end
      end
      default: begin
        // Unreachable encoding: behave as reset but keep the cycle count.
        state_d     = SYNC;
        phase_d     = '0;
        err_d       = 1'b0;
        err_code_d  = E_NONE;
        dwell_d     = '0;
        last_code_d = '0;
      end
    endcase

    phase_vld_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= E_NONE;
      cycles_q    <= '0;
      dwell_q     <= '0;
      last_code_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      phase_vld_q <= phase_vld_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cycles_q    <= cycles_d;
      dwell_q     <= dwell_d;
      last_code_q <= last_code_d;
    end
  end

  assign phase     = phase_q;
  assign phase_vld = phase_vld_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign cycles    = cycles_q;
  assign dwell     = dwell_q;

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receive-side checker for the 4-bit one-hot traffic light bus driven by the traffic sequencer.
- Samples the light code every clock and decodes it to a 2-bit phase.
- Checks one-hot legality, the legal phase order and per-phase dwell time, and counts completed light cycles.
- Sits between the sequencer output and the status/fault logic; errors are sticky until explicitly cleared.

Parameters:
- MIN_DWELL, 1: minimum clocks a red/green/yellow code must be held before changing.
- MAX_DWELL, 15: maximum clocks a red/green/yellow code may be held; black is exempt.
- DW_W, 4: dwell counter width; must satisfy 2^DW_W - 1 >= MAX_DWELL.
- CNT_W, 8: width of the completed-cycle counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- light  in  4  light code: 1000 black, 0100 red, 0010 green, 0001 yellow.
- clr_err  in  1  one-clock pulse that clears the sticky error and returns to SYNC.
- phase  out  2  decoded phase of the last accepted code: 00 black, 01 red, 10 green, 11 yellow.
- phase_vld  out  1  high while in RUN.
- err  out  1  sticky error flag.
- err_code  out  3  first error cause: 000 none, 001 not one-hot, 010 illegal transition, 011 dwell short, 100 dwell long.
- cycles  out  CNT_W  count of yellow->red transitions; saturates at all-ones.
- dwell  out  DW_W  clocks the current code has been held; saturates.

Behaviour:
- Reset (rst_n low at an edge): state=SYNC, phase=00, phase_vld=0, err=0, err_code=000, cycles=0, dwell=0, last_code=0000. Reset overrides clr_err and any in-progress check.
- Latency: all outputs are registered. An input change present before edge t is reflected after edge t (1 clock).
- SYNC state:
  - light=1000 or 0100: load last_code, set phase, set dwell=1, go to RUN, phase_vld=1.
  - Any other value (including 0010 and 0001): stay in SYNC, no error.
- RUN state, at each edge, with light compared against last_code:
  - Same code: dwell increments (saturating). If the code is not black and dwell already equals MAX_DWELL, raise dwell-long.
  - Different legal one-hot code: allowed transitions are black->red, red->green, green->yellow, yellow->red.
    - Legal transition with dwell >= MIN_DWELL (black exempt from the MIN check): update last_code and phase, set dwell=1.
    - yellow->red also increments cycles (saturating).
    - Legal transition with dwell < MIN_DWELL: dwell-short.
  - Other one-hot code (e.g. red->yellow, any->black, yellow->green): illegal transition.
  - Not one-hot (0000, two or more bits set): not-one-hot.
- Error priority when more than one applies at the same edge: 001 > 010 > 011 > 100.
- On any error:
  - Go to FAULT; err=1; err_code latched to the cause.
  - phase_vld=0; phase, cycles and dwell hold their values.
- FAULT state:
  - Ignores light; err_code never overwritten.
  - clr_err=1 at an edge: err=0, err_code=000, dwell=0, state=SYNC. cycles is not cleared.
- clr_err in SYNC or RUN is a no-op.
- States are encoded in 2 bits. The unused encoding returns to SYNC on the next edge with outputs as after reset, except cycles, which holds.

Test Plan:
- Reset then light 1000 x3, 0100, 0010, 0001, 0100 (one clock each) -> phase 00,00,00,01,10,11,01; phase_vld=1 from the first edge; cycles=1; err=0.
- In RUN at red, drive light=0110 -> next edge err=1, err_code=001, phase_vld=0, phase stays 01; then clr_err pulse -> err=0, err_code=000, state SYNC; 0100 re-enters RUN.
- In RUN at red, drive 0001 (red->yellow) -> err_code=010. Separately, green->1000 -> err_code=010.
- MIN_DWELL=3: red held 2 clocks then green -> err_code=011. Red held 3 clocks then green -> no error.
- MAX_DWELL=15: green held 16 clocks -> error on the 16th edge, err_code=100, dwell=15. Black held 100 clocks -> no error.
- CNT_W=2: run 5 full red/green/yellow cycles -> cycles=3 (saturated). Assert rst_n=0 for one clock mid-green -> all outputs are reset values on the next edge.
